// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the synthetic video pattern generator.
package video_pattern_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECKER, PAT_SOLID} pattern_t;

  // Field order matches the tdata packing {r, b, g}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] g;
  } rgb_t;

  // Index 0 (white) is the leftmost bar; the list is written MSB-first.
  localparam rgb_t [7:0] BAR_COLORS = {
    24'h000000, 24'h00FF00, 24'hFF0000, 24'hFFFF00,
    24'h0000FF, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF
  };

endpackage

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video beat bundle: tuser = start of frame, tlast = end of line.
interface video_pattern_gen_if;
  import video_pattern_pkg::*;

  rgb_t tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/video_pattern_pixel.sv
// Combinational pixel colour for one (x, y) position of the selected pattern.
// Scrolling ramp/checker is enabled by defining VIDEO_PATTERN_GEN_MOTION_EN.
module video_pattern_pixel
  import video_pattern_pkg::*;
(
  input  pattern_t    pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [2:0]  bar_idx,
  input  rgb_t        color,
  input  logic [15:0] frame_count,
  output rgb_t        pixel
);

  logic [7:0] px;
  logic       unused_bits;

`ifdef VIDEO_PATTERN_GEN_MOTION_EN
  assign px          = x[7:0] + frame_count[7:0];
  assign unused_bits = ^{x[15:8], y[15:5], y[3:0], frame_count[15:8]};
`else
  assign px          = x[7:0];
  assign unused_bits = ^{x[15:8], y[15:5], y[3:0], frame_count};
`endif

  always_comb begin
    pixel = color;
    unique case (pattern)
      PAT_BARS:    pixel = BAR_COLORS[bar_idx];
      PAT_RAMP:    pixel = rgb_t'({px, px, px});
      PAT_CHECKER: pixel = (px[4] ^ y[4]) ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
      PAT_SOLID:   pixel = color;
      default:     pixel = color;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern source: IDLE/ACTIVE/GAP frame sequencer with a registered
// output stage. Optional scrolling patterns via VIDEO_PATTERN_GEN_MOTION_EN.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 4096,
  parameter int unsigned MAX_HEIGHT = 4096,
  parameter int unsigned FRAME_GAP  = 16
) (
  input  logic                       m_axis_video_aclk,
  input  logic                       m_axis_video_aresetn,
  input  logic                       enable,
  input  logic [15:0]                cfg_width,
  input  logic [15:0]                cfg_height,
  input  logic [1:0]                 cfg_pattern,
  input  logic [23:0]                cfg_color,
  video_pattern_gen_if.master        m_axis_video,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic                       cfg_error
);

  localparam int unsigned XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned YW = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1;
  localparam int unsigned GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  state_t        state_q, state_d, launch_state;
  logic [15:0]   width_q, height_q;
  pattern_t      pattern_q;
  rgb_t          color_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [15:0]   bar_cnt_q;
  logic [2:0]    bar_idx_q;
  logic [GW-1:0] gap_cnt_q;
  logic          pending_q;
  logic [15:0]   frame_count_q;
  logic          cfg_error_q;
  rgb_t          tdata_q;
  logic          tvalid_q, tlast_q, tuser_q, tend_q;

  logic cfg_bad, accept, frame_end, gap_done, decide, relatch, start, load;
  logic x_last, y_last, bar_last;
  rgb_t pix;

  assign cfg_bad = (cfg_width < 16'd8) || (32'(cfg_width) > MAX_WIDTH) ||
                   (cfg_height == 16'd0) || (32'(cfg_height) > MAX_HEIGHT);

  assign accept    = tvalid_q && m_axis_video.tready;
  assign frame_end = accept && tend_q;
  assign gap_done  = (state_q == GAP) && (gap_cnt_q == GW'(FRAME_GAP - 1));
  assign decide    = (FRAME_GAP == 0) ? frame_end : gap_done;
  assign relatch   = enable && ((state_q == IDLE) || decide);
  // A new frame starts on entry to ACTIVE, including ACTIVE->ACTIVE when FRAME_GAP is 0.
  assign start     = (state_d == ACTIVE) && ((state_q != ACTIVE) || frame_end);

  assign x_last   = (16'(x_q) == width_q - 16'd1);
  assign y_last   = (16'(y_q) == height_q - 16'd1);
  assign bar_last = (bar_cnt_q == (width_q >> 3) - 16'd1);

  always_ff @(posedge m_axis_video_aclk) begin
    if (!m_axis_video_aresetn) state_q <= IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    launch_state = (enable && !cfg_bad) ? ACTIVE : IDLE;
    state_d      = state_q;
    unique case (state_q)
      IDLE:    if (enable && !cfg_bad) state_d = ACTIVE;
      ACTIVE:  if (frame_end) state_d = (FRAME_GAP == 0) ? launch_state : GAP;
      GAP:     if (gap_done) state_d = launch_state;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ACTIVE) || (state_q == GAP);
    load = (state_q == ACTIVE) && pending_q && (!tvalid_q || m_axis_video.tready);
  end

  video_pattern_pixel u_pixel (
    .pattern     (pattern_q),
    .x           (16'(x_q)),
    .y           (16'(y_q)),
    .bar_idx     (bar_idx_q),
    .color       (color_q),
    .frame_count (frame_count_q),
    .pixel       (pix)
  );

  always_ff @(posedge m_axis_video_aclk) begin
    if (!m_axis_video_aresetn) begin
      width_q       <= '0;
      height_q      <= '0;
      pattern_q     <= PAT_BARS;
      color_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      gap_cnt_q     <= '0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      cfg_error_q   <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      tend_q        <= 1'b0;
    end else begin
      if (relatch) begin
        width_q     <= cfg_width;
        height_q    <= cfg_height;
        pattern_q   <= pattern_t'(cfg_pattern);
        color_q     <= rgb_t'(cfg_color);
        cfg_error_q <= cfg_bad;
      end
      if (start) begin
        x_q       <= '0;
        y_q       <= '0;
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
        pending_q <= 1'b1;
      end else if (load) begin
        tdata_q <= pix;
        tuser_q <= (x_q == '0) && (y_q == '0);
        tlast_q <= x_last;
        tend_q  <= x_last && y_last;
        if (x_last) begin
          x_q       <= '0;
          bar_cnt_q <= '0;
          bar_idx_q <= '0;
          if (y_last) pending_q <= 1'b0;
          else        y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
          if (bar_last) begin
            bar_cnt_q <= '0;
            if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 3'd1;
          end else begin
            bar_cnt_q <= bar_cnt_q + 16'd1;
          end
        end
      end
      if (load)        tvalid_q <= 1'b1;
      else if (accept) tvalid_q <= 1'b0;
      if (frame_end) frame_count_q <= frame_count_q + 16'd1;
      if (frame_end)            gap_cnt_q <= '0;
      else if (state_q == GAP)  gap_cnt_q <= gap_cnt_q + GW'(1);
    end
  end

  assign m_axis_video.tdata  = tdata_q;
  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tlast  = tlast_q;
  assign m_axis_video.tuser  = tuser_q;
  assign frame_count         = frame_count_q;
  assign cfg_error           = cfg_error_q;

endmodule
